datapath: RTL and testbench
===========================

// Module: datapath
// PURPOSE
//  Timing datapath for the traffic-light controller; the counter side of the clr_*/inc_* <-> sig_* interface.
//  Consumes the six clr/inc strobes from controlpath and runs a prescaler plus G/Y/R phase counters.
//  Returns the four phase-done signals that step the controller FSM, and drives the registered lamp outputs.
// PARAMETERS
//  TICK_DIV     10  clk cycles per timing tick (>=1)
//  GREEN_TICKS  30  ticks spent in green phase (>=1, < 2**CNT_W)
//  YELLOW_TICKS 5   ticks spent in each yellow phase (>=1, < 2**CNT_W)
//  RED_TICKS    30  ticks spent in red phase (>=1, < 2**CNT_W)
//  CNT_W        8   width of each phase counter
// PORTS
//  clk        in  1  system clock, rising edge
//  rst_n      in  1  asynchronous active-low reset
//  clr_G      in  1  clear green counter
//  inc_G      in  1  green phase active, count ticks
//  clr_Y      in  1  clear yellow counter
//  inc_Y      in  1  yellow phase active, count ticks
//  clr_R      in  1  clear red counter
//  inc_R      in  1  red phase active, count ticks
//  sig_1to2   out 1  green done -> yellow
//  sig_2to3   out 1  yellow (after green) done -> red
//  sig_3to2   out 1  red done -> yellow
//  sig_2to1   out 1  yellow (after red) done -> green
//  lamp_g     out 1  green lamp
//  lamp_y     out 1  yellow lamp
//  lamp_r     out 1  red lamp
// BEHAVIOUR
//  Reset (async, rst_n=0): pre=0, cnt_G/Y/R=0, phase_q=NONE, yel_after_red=0, lamp_r=1, lamp_g=lamp_y=0; all sig_*=0.
//  Phase: GREEN if inc_G, else YELLOW if inc_Y, else RED if inc_R, else NONE (priority if >1 inc high).
//   phase_q registers phase every cycle; phase_chg = (phase != phase_q).
//  Prescaler pre: cleared when phase_chg or phase==NONE; else wraps 0..TICK_DIV-1.
//   tick = (phase!=NONE) & ~phase_chg & (pre==TICK_DIV-1).
//  Counter X in {G,Y,R}: clr_X=1 -> 0 (clr beats inc); else inc_X & tick & cnt_X<X_TICKS -> +1;
//   else hold. Saturates at X_TICKS, never wraps.
//  yel_after_red: set on any cycle with inc_R=1, cleared on any cycle with inc_G=1, else hold.
//  Done outputs (combinational, level, held until controller leaves phase and clears counter):
//   sig_1to2 = inc_G & (cnt_G==GREEN_TICKS)
//   sig_2to3 = inc_Y & (cnt_Y==YELLOW_TICKS) & ~yel_after_red
//   sig_3to2 = inc_R & (cnt_R==RED_TICKS)
//   sig_2to1 = inc_Y & (cnt_Y==YELLOW_TICKS) &  yel_after_red
//  Latency: with first inc_X cycle = cycle 0, sig rises in cycle X_TICKS*TICK_DIV+1.
//  Lamps (registered, 1-cycle lag): lamp_g<=phase==GREEN; lamp_y<=phase==YELLOW; lamp_r<=phase==RED|NONE.
//   Exactly one lamp is on at all times; NONE shows red (fail-safe).
//  Boundaries: clr_X and inc_X together -> counter 0, no tick counted.
//   inc dropped mid-phase -> counter holds, prescaler cleared; resume restarts prescaler, keeps count.
//   rst_n low mid-phase -> immediate return to reset values regardless of clk.
//   TICK_DIV=1 -> tick every non-change cycle of an active phase.
// TESTING
//  T1 reset: rst_n=0 between edges -> all sig_*=0, lamp_r=1, counters 0 without a clk edge.
//  T2 green timing, TICK_DIV=4 GREEN_TICKS=3, inc_G held from cycle 0 -> sig_1to2 first high in cycle 13, held while inc_G.
//  T3 full loop with controlpath, start=1 -> sig order 1to2, 2to3, 3to2, 2to1, 1to2; lamps G,Y,R,Y,G; one lamp on.
//  T4 yellow steering: yellow after green -> only sig_2to3; yellow after red -> only sig_2to1.
//  T5 clr+inc together on G for 20 cycles -> cnt_G stays 0, sig_1to2 never asserts.
//  T6 reset pulse mid-red at cnt_R=2 -> cnt_R=0, lamp_r=1, sig_3to2=0; re-run gives full RED_TICKS*TICK_DIV+1 delay.

Source files
------------

// File: rtl/datapath.sv
// Traffic-light timing datapath: phase prescaler, saturating G/Y/R tick counters,
// phase-done strobes back to the controller and registered fail-safe lamp drivers.
`timescale 1ns/1ps
module datapath #(
   parameter int TICK_DIV     = 10,
   parameter int GREEN_TICKS  = 30,
   parameter int YELLOW_TICKS = 5,
   parameter int RED_TICKS    = 30,
   parameter int CNT_W        = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_G,
   input  logic inc_G,
   input  logic clr_Y,
   input  logic inc_Y,
   input  logic clr_R,
   input  logic inc_R,
   output logic sig_1to2,
   output logic sig_2to3,
   output logic sig_3to2,
   output logic sig_2to1,
   output logic lamp_g,
   output logic lamp_y,
   output logic lamp_r
);

   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] G_MAX    = CNT_W'(GREEN_TICKS);
   localparam logic [CNT_W-1:0] Y_MAX    = CNT_W'(YELLOW_TICKS);
   localparam logic [CNT_W-1:0] R_MAX    = CNT_W'(RED_TICKS);

   typedef enum logic [1:0] {
      PH_NONE   = 2'd0,
      PH_GREEN  = 2'd1,
      PH_YELLOW = 2'd2,
      PH_RED    = 2'd3
   } phase_t;

   phase_t           phase;
   phase_t           phase_q;
   logic             phase_chg;
   logic             tick;
   logic [PRE_W-1:0] pre;
   logic [CNT_W-1:0] cnt_G;
   logic [CNT_W-1:0] cnt_Y;
   logic [CNT_W-1:0] cnt_R;
   logic             yel_after_red;

   // Green wins if the controller ever raises more than one inc strobe.
   always_comb begin
      phase = PH_NONE;
      if (inc_G)
         phase = PH_GREEN;
      else if (inc_Y)
         phase = PH_YELLOW;
      else if (inc_R)
         phase = PH_RED;
   end

   assign phase_chg = (phase != phase_q);
   assign tick      = (phase != PH_NONE) && !phase_chg && (pre == PRE_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= PH_NONE;
         pre     <= '0;
      end else begin
         phase_q <= phase;
         if (phase_chg || (phase == PH_NONE) || (pre == PRE_LAST))
            pre <= '0;
         else
            pre <= pre + 1'b1;
      end
   end

   // Counters saturate at their phase length so the done level holds until cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_G <= '0;
         cnt_Y <= '0;
         cnt_R <= '0;
      end else begin
         if (clr_G)
            cnt_G <= '0;
         else if (inc_G && tick && (cnt_G < G_MAX))
            cnt_G <= cnt_G + 1'b1;

         if (clr_Y)
            cnt_Y <= '0;
         else if (inc_Y && tick && (cnt_Y < Y_MAX))
            cnt_Y <= cnt_Y + 1'b1;

         if (clr_R)
            cnt_R <= '0;
         else if (inc_R && tick && (cnt_R < R_MAX))
            cnt_R <= cnt_R + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         yel_after_red <= 1'b0;
         lamp_g        <= 1'b0;
         lamp_y        <= 1'b0;
         lamp_r        <= 1'b1;
      end else begin
         if (inc_R)
            yel_after_red <= 1'b1;
         else if (inc_G)
            yel_after_red <= 1'b0;
         lamp_g <= (phase == PH_GREEN);
         lamp_y <= (phase == PH_YELLOW);
         lamp_r <= (phase == PH_RED) || (phase == PH_NONE);
      end
   end

   // Yellow finishes toward red or green depending on which phase preceded it.
   assign sig_1to2 = inc_G && (cnt_G == G_MAX);
   assign sig_2to3 = inc_Y && (cnt_Y == Y_MAX) && !yel_after_red;
   assign sig_3to2 = inc_R && (cnt_R == R_MAX);
   assign sig_2to1 = inc_Y && (cnt_Y == Y_MAX) &&  yel_after_red;

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed timing scenarios plus randomized
// stimulus against a run-length based reference model of the tick counters.
`timescale 1ns/1ps
module tb_datapath;

   localparam int D  = 4;
   localparam int GT = 3;
   localparam int YT = 2;
   localparam int RT = 3;

   logic clk = 1'b0;
   logic rst_n;
   logic clr_G, inc_G, clr_Y, inc_Y, clr_R, inc_R;
   logic sig_1to2, sig_2to3, sig_3to2, sig_2to1;
   logic lamp_g, lamp_y, lamp_r;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state: counts, previous phase, length of current run.
   int       m_cnt[3];
   int       m_prev;
   int       m_run;
   bit       m_yar;
   bit [2:0] m_lamp;

   always #5 clk = ~clk;

   datapath #(
      .TICK_DIV(D), .GREEN_TICKS(GT), .YELLOW_TICKS(YT), .RED_TICKS(RT), .CNT_W(8)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .clr_G(clr_G), .inc_G(inc_G), .clr_Y(clr_Y), .inc_Y(inc_Y),
      .clr_R(clr_R), .inc_R(inc_R),
      .sig_1to2(sig_1to2), .sig_2to3(sig_2to3), .sig_3to2(sig_3to2), .sig_2to1(sig_2to1),
      .lamp_g(lamp_g), .lamp_y(lamp_y), .lamp_r(lamp_r)
   );

   function automatic logic [3:0] obs_sig();
      return {sig_1to2, sig_2to3, sig_3to2, sig_2to1};
   endfunction

   function automatic logic [2:0] obs_lamp();
      return {lamp_g, lamp_y, lamp_r};
   endfunction

   function automatic int cur_phase();
      if (inc_G) return 1;
      if (inc_Y) return 2;
      if (inc_R) return 3;
      return 0;
   endfunction

   function automatic logic [3:0] exp_sig();
      return {inc_G && (m_cnt[0] == GT),
              inc_Y && (m_cnt[1] == YT) && !m_yar,
              inc_R && (m_cnt[2] == RT),
              inc_Y && (m_cnt[1] == YT) && m_yar};
   endfunction

   task automatic model_reset();
      m_cnt  = '{0, 0, 0};
      m_prev = 0;
      m_run  = 0;
      m_yar  = 1'b0;
      m_lamp = 3'b001;
   endtask

   // Bit order {R,Y,G} for both vectors.
   task automatic set_in(input bit [2:0] clr, input bit [2:0] inc);
      clr_G = clr[0]; clr_Y = clr[1]; clr_R = clr[2];
      inc_G = inc[0]; inc_Y = inc[1]; inc_R = inc[2];
   endtask

   // A tick lands on every D-th cycle of an unbroken active run, never its first.
   task automatic step();
      int p, n;
      bit tk;
      bit [2:0] clr, inc;
      int lim[3];
      lim = '{GT, YT, RT};
      if (!rst_n) begin
         model_reset();
      end else begin
         p   = cur_phase();
         n   = (p != m_prev) ? 0 : m_run;
         tk  = (p != 0) && (n >= 1) && (n % D == 0);
         clr = {clr_R, clr_Y, clr_G};
         inc = {inc_R, inc_Y, inc_G};
         for (int i = 0; i < 3; i++) begin
            if (clr[i])
               m_cnt[i] = 0;
            else if (inc[i] && tk && m_cnt[i] < lim[i])
               m_cnt[i] = m_cnt[i] + 1;
         end
         if (inc_R)
            m_yar = 1'b1;
         else if (inc_G)
            m_yar = 1'b0;
         m_lamp = {p == 1, p == 2, (p == 3) || (p == 0)};
         m_run  = (p == 0) ? 0 : n + 1;
         m_prev = p;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      set_in(3'b000, 3'b000);
      rst_n = 1'b0;
      model_reset();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      set_in(3'b000, 3'b100);
      repeat (6) step();
      #1;
      n_cmp++;
      if (dut.cnt_R !== 8'(m_cnt[2])) begin
         n_err++;
         $display("[TB] FAIL reset_pre_cnt_R: got %0d expected %0d", dut.cnt_R, m_cnt[2]);
      end
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if (obs_sig() !== 4'b0000) begin
         n_err++;
         $display("[TB] FAIL reset_sig: got %b expected 0000", obs_sig());
      end
      n_cmp++;
      if (obs_lamp() !== 3'b001) begin
         n_err++;
         $display("[TB] FAIL reset_lamp: got %b expected 001", obs_lamp());
      end
      n_cmp++;
      if ({dut.cnt_G, dut.cnt_Y, dut.cnt_R} !== 24'd0) begin
         n_err++;
         $display("[TB] FAIL reset_cnt: got %h expected 000000", {dut.cnt_G, dut.cnt_Y, dut.cnt_R});
      end
      step();
      set_in(3'b000, 3'b000);
      rst_n = 1'b1;
   endtask

   task automatic test_green_timing();
      do_reset();
      set_in(3'b000, 3'b001);
      for (int c = 0; c <= 20; c++) begin
         #1;
         n_cmp++;
         if (sig_1to2 !== (c >= GT * D + 1)) begin
            n_err++;
            $display("[TB] FAIL green_latency c=%0d: got %b expected %b", c, sig_1to2, c >= GT * D + 1);
         end
         n_cmp++;
         if (obs_sig() !== exp_sig()) begin
            n_err++;
            $display("[TB] FAIL green_sig c=%0d: got %b expected %b", c, obs_sig(), exp_sig());
         end
         if (c >= 1) begin
            n_cmp++;
            if (obs_lamp() !== 3'b100) begin
               n_err++;
               $display("[TB] FAIL green_lamp c=%0d: got %b expected 100", c, obs_lamp());
            end
         end
         step();
      end
      set_in(3'b001, 3'b000);
      step();
   endtask

   // The bench plays the controller: advance phase on each done strobe.
   task automatic test_loop();
      int s;
      int ev[$];
      logic [2:0] lc[$];
      logic [2:0] prev_lamp;
      logic [3:0] o;
      int exp_ev[5];
      logic [2:0] exp_lc[5];
      exp_ev = '{0, 1, 2, 3, 0};
      exp_lc = '{3'b100, 3'b010, 3'b001, 3'b010, 3'b100};
      do_reset();
      s = 0;
      prev_lamp = 3'b001;
      for (int cyc = 0; cyc < 200 && ev.size() < 5; cyc++) begin
         case (s)
            0:       set_in(3'b110, 3'b001);
            2:       set_in(3'b011, 3'b100);
            default: set_in(3'b101, 3'b010);
         endcase
         #1;
         o = obs_sig();
         n_cmp++;
         if (o !== exp_sig()) begin
            n_err++;
            $display("[TB] FAIL loop_sig cyc=%0d: got %b expected %b", cyc, o, exp_sig());
         end
         n_cmp++;
         if (!$onehot(obs_lamp()) || obs_lamp() !== m_lamp) begin
            n_err++;
            $display("[TB] FAIL loop_lamp cyc=%0d: got %b expected %b", cyc, obs_lamp(), m_lamp);
         end
         if (obs_lamp() !== prev_lamp) begin
            lc.push_back(obs_lamp());
            prev_lamp = obs_lamp();
         end
         if (o !== 4'b0000) begin
            case (o)
               4'b1000: ev.push_back(0);
               4'b0100: ev.push_back(1);
               4'b0010: ev.push_back(2);
               4'b0001: ev.push_back(3);
               default: ev.push_back(9);
            endcase
            s = (s + 1) % 4;
         end
         step();
      end
      n_cmp++;
      if (ev.size() != 5 || lc.size() != 5) begin
         n_err++;
         $display("[TB] FAIL loop_count: got %0d sigs %0d lamp changes expected 5 and 5", ev.size(), lc.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (ev[i] != exp_ev[i]) begin
               n_err++;
               $display("[TB] FAIL loop_order[%0d]: got %0d expected %0d", i, ev[i], exp_ev[i]);
            end
            n_cmp++;
            if (lc[i] !== exp_lc[i]) begin
               n_err++;
               $display("[TB] FAIL loop_lamps[%0d]: got %b expected %b", i, lc[i], exp_lc[i]);
            end
         end
      end
   endtask

   task automatic test_yellow_steering();
      do_reset();
      for (int pass = 0; pass < 2; pass++) begin
         set_in(3'b000, (pass == 0) ? 3'b001 : 3'b100);
         step();
         set_in(3'b010, 3'b000);
         step();
         set_in(3'b000, 3'b010);
         for (int c = 0; c <= YT * D + 1; c++) begin
            #1;
            n_cmp++;
            if ({sig_2to3, sig_2to1} !== ((c >= YT * D + 1) ? ((pass == 0) ? 2'b10 : 2'b01) : 2'b00)) begin
               n_err++;
               $display("[TB] FAIL yellow_steer pass=%0d c=%0d: got %b%b", pass, c, sig_2to3, sig_2to1);
            end
            n_cmp++;
            if (obs_sig() !== exp_sig()) begin
               n_err++;
               $display("[TB] FAIL yellow_sig pass=%0d c=%0d: got %b expected %b", pass, c, obs_sig(), exp_sig());
            end
            step();
         end
      end
   endtask

   task automatic test_clr_inc();
      do_reset();
      set_in(3'b001, 3'b001);
      for (int c = 0; c < 20; c++) begin
         #1;
         n_cmp++;
         if (sig_1to2 !== 1'b0 || dut.cnt_G !== 8'd0) begin
            n_err++;
            $display("[TB] FAIL clr_inc c=%0d: got sig=%b cnt=%0d expected sig=0 cnt=0", c, sig_1to2, dut.cnt_G);
         end
         step();
      end
   endtask

   task automatic test_reset_mid_red();
      do_reset();
      set_in(3'b000, 3'b100);
      for (int c = 0; c < 2 * D + 1; c++) step();
      #1;
      n_cmp++;
      if (dut.cnt_R !== 8'd2) begin
         n_err++;
         $display("[TB] FAIL midred_cnt_before: got %0d expected 2", dut.cnt_R);
      end
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if (dut.cnt_R !== 8'd0 || lamp_r !== 1'b1 || sig_3to2 !== 1'b0) begin
         n_err++;
         $display("[TB] FAIL midred_reset: got cnt=%0d lamp_r=%b sig=%b expected 0 1 0", dut.cnt_R, lamp_r, sig_3to2);
      end
      step();
      set_in(3'b000, 3'b000);
      rst_n = 1'b1;
      step();
      set_in(3'b000, 3'b100);
      for (int c = 0; c <= RT * D + 2; c++) begin
         #1;
         n_cmp++;
         if (sig_3to2 !== (c >= RT * D + 1)) begin
            n_err++;
            $display("[TB] FAIL midred_rerun c=%0d: got %b expected %b", c, sig_3to2, c >= RT * D + 1);
         end
         step();
      end
   endtask

   task automatic test_random();
      int hold;
      bit [2:0] inc;
      do_reset();
      hold = 0;
      inc  = 3'b000;
      for (int k = 0; k < 600; k++) begin
         if (hold == 0) begin
            inc  = 3'($urandom_range(0, 7));
            hold = $urandom_range(1, 20);
            set_in(($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000, inc);
         end else begin
            set_in(3'b000, inc);
         end
         #1;
         n_cmp++;
         if (obs_sig() !== exp_sig()) begin
            n_err++;
            $display("[TB] FAIL random_sig k=%0d: got %b expected %b", k, obs_sig(), exp_sig());
         end
         n_cmp++;
         if (obs_lamp() !== m_lamp) begin
            n_err++;
            $display("[TB] FAIL random_lamp k=%0d: got %b expected %b", k, obs_lamp(), m_lamp);
         end
         if ($urandom_range(0, 149) == 0) begin
            #1;
            rst_n = 1'b0;
            model_reset();
            #1;
            rst_n = 1'b1;
         end
         hold--;
         step();
      end
   endtask

   initial begin
      rst_n = 1'b0;
      set_in(3'b000, 3'b000);
      model_reset();
      @(negedge clk);
      test_reset();
      test_green_timing();
      test_loop();
      test_yellow_steering();
      test_clr_inc();
      test_reset_mid_red();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
